// File: rtl/pf_csr_regfile.sv
// pf_csr_regfile: AXI4-Lite CSR bank for one physical function (ID/SCRATCH/CTRL/STATUS/counters).
// Optional PF tag check on awuser/aruser enabled by defining PF_CSR_USER_CHECK_EN.
module pf_csr_regfile #(
    parameter logic [29:0] PF_ID    = 30'd0,
    parameter logic [31:0] ID_VALUE = 32'h0CF5_0001
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [11:0] s_axil_awaddr,
    input  logic [29:0] s_axil_awuser,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [11:0] s_axil_araddr,
    input  logic [29:0] s_axil_aruser,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    input  logic [31:0] status_i,
    output logic [7:0]  ctrl_o
);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e    r_wstate, w_wstate_n;
    r_state_e    r_rstate, w_rstate_n;
    logic [11:2] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_scratch, r_wr_cnt, r_rd_cnt, r_err_cnt, r_rdata;
    logic [7:0]  r_ctrl;
    logic [1:0]  r_bresp, r_rresp;
    logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic        w_wuser_ok, w_ruser_ok, w_wr_ok, w_rd_ok, w_wr_err, w_rd_err;
    logic [11:2] w_waddr;
    logic [31:0] w_wdata, w_rval;
    logic [3:0]  w_wstrb;
    logic [1:0]  w_wresp, w_rresp;
    logic        w_unused_bits;

    function automatic logic mapped(input logic [11:2] a);
        return a[11:6] == 6'd0 && a[5:2] <= 4'd6;
    endfunction

    assign s_axil_awready = !areset && (r_wstate == W_IDLE || r_wstate == W_HAVE_D);
    assign s_axil_wready  = !areset && (r_wstate == W_IDLE || r_wstate == W_HAVE_A);
    assign s_axil_bvalid  = !areset && r_wstate == W_RESP;
    assign s_axil_arready = !areset && r_rstate == R_IDLE;
    assign s_axil_rvalid  = !areset && r_rstate == R_RESP;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign ctrl_o         = r_ctrl;

    assign w_aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_w_hs   = s_axil_wvalid && s_axil_wready;
    assign w_ar_hs  = s_axil_arvalid && s_axil_arready;
    // The edge that completes the second of AW/W is the commit edge
    assign w_commit = (w_aw_hs || r_wstate == W_HAVE_A) && (w_w_hs || r_wstate == W_HAVE_D);
    assign w_waddr  = r_wstate == W_HAVE_A ? r_awaddr : s_axil_awaddr[11:2];
    assign w_wdata  = r_wstate == W_HAVE_D ? r_wdata : s_axil_wdata;
    assign w_wstrb  = r_wstate == W_HAVE_D ? r_wstrb : s_axil_wstrb;

`ifdef PF_CSR_USER_CHECK_EN
    logic [29:0] r_awuser;
    always_ff @(posedge aclk)
        if (w_aw_hs) r_awuser <= s_axil_awuser;
    assign w_wuser_ok    = (r_wstate == W_HAVE_A ? r_awuser : s_axil_awuser) == PF_ID;
    assign w_ruser_ok    = s_axil_aruser == PF_ID;
    assign w_unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
`else
    assign w_wuser_ok    = 1'b1;
    assign w_ruser_ok    = 1'b1;
    assign w_unused_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_awuser, s_axil_aruser};
`endif

    assign w_wresp  = !w_wuser_ok ? 2'b10 : mapped(w_waddr) ? OKAY : DECERR;
    assign w_rresp  = !w_ruser_ok ? 2'b10 : mapped(s_axil_araddr[11:2]) ? OKAY : DECERR;
    assign w_wr_ok  = w_commit && w_wresp == OKAY;
    assign w_wr_err = w_commit && w_wresp != OKAY;
    assign w_rd_ok  = w_ar_hs && w_rresp == OKAY;
    assign w_rd_err = w_ar_hs && w_rresp != OKAY;

    always_comb begin
        w_rval = 32'd0;
        case (s_axil_araddr[5:2])
            4'd0:    w_rval = ID_VALUE;
            4'd1:    w_rval = r_scratch;
            4'd2:    w_rval = {24'd0, r_ctrl};
            4'd3:    w_rval = status_i;
            4'd4:    w_rval = r_wr_cnt;
            4'd5:    w_rval = r_rd_cnt;
            4'd6:    w_rval = r_err_cnt;
            default: w_rval = 32'd0;
        endcase
    end

    always_comb begin
        w_wstate_n = r_wstate;
        if (w_commit) w_wstate_n = W_RESP;
        else if (r_wstate == W_RESP && s_axil_bready) w_wstate_n = W_IDLE;
        else if (w_aw_hs) w_wstate_n = W_HAVE_A;
        else if (w_w_hs) w_wstate_n = W_HAVE_D;
        w_rstate_n = (r_rstate == R_IDLE && w_ar_hs) ? R_RESP :
                     (r_rstate == R_RESP && s_axil_rready) ? R_IDLE : r_rstate;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_scratch <= 32'd0;
            r_ctrl    <= 8'd0;
            r_wr_cnt  <= 32'd0;
            r_rd_cnt  <= 32'd0;
            r_err_cnt <= 32'd0;
            r_bresp   <= 2'b00;
            r_rresp   <= 2'b00;
            r_rdata   <= 32'd0;
        end else begin
            r_wstate <= w_wstate_n;
            r_rstate <= w_rstate_n;
            if (w_aw_hs) r_awaddr <= s_axil_awaddr[11:2];
            if (w_w_hs) begin
                r_wdata <= s_axil_wdata;
                r_wstrb <= s_axil_wstrb;
            end
            if (w_commit) r_bresp <= w_wresp;
            for (int i = 0; i < 4; i++)
                if (w_wr_ok && w_waddr[5:2] == 4'd1 && w_wstrb[i]) r_scratch[8*i +: 8] <= w_wdata[8*i +: 8];
            if (w_wr_ok && w_waddr[5:2] == 4'd2 && w_wstrb[0]) r_ctrl <= w_wdata[7:0];
            if (w_ar_hs) begin
                r_rdata <= w_rresp == OKAY ? w_rval : 32'd0;
                r_rresp <= w_rresp;
            end
            r_wr_cnt  <= r_wr_cnt + {31'd0, w_wr_ok};
            r_rd_cnt  <= r_rd_cnt + {31'd0, w_rd_ok};
            r_err_cnt <= r_err_cnt + {31'd0, w_wr_err} + {31'd0, w_rd_err};
        end
    end
endmodule

// File: tb/tb_pf_csr_regfile.sv
// tb_pf_csr_regfile: randomized scoreboard bench for pf_csr_regfile against a register-map model.
// Define PF_CSR_USER_CHECK_EN for both files to exercise the PF tag check (PF_ID=1).
module tb_pf_csr_regfile;
`ifdef PF_CSR_USER_CHECK_EN
    localparam logic [29:0] PFID = 30'd1;
`else
    localparam logic [29:0] PFID = 30'd0;
`endif
    localparam logic [31:0] IDV = 32'h0CF5_0001;

    logic        aclk = 1'b0, areset = 1'b1;
    logic [11:0] s_axil_awaddr = '0, s_axil_araddr = '0;
    logic [29:0] s_axil_awuser = '0, s_axil_aruser = '0;
    logic        s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_bready = 1'b0;
    logic        s_axil_arvalid = 1'b0, s_axil_rready = 1'b0;
    logic [31:0] s_axil_wdata = '0, status_i = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic [31:0] s_axil_rdata;
    logic [7:0]  ctrl_o;

    pf_csr_regfile #(.PF_ID(PFID), .ID_VALUE(IDV)) dut (
        .aclk(aclk), .areset(areset),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awuser(s_axil_awuser),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_aruser(s_axil_aruser),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .status_i(status_i), .ctrl_o(ctrl_o)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0, n_err = 0;
    logic [1:0]  wq[$];
    logic [33:0] rq[$];
    logic [31:0] m_scratch = 0, m_wr = 0, m_rd = 0, m_err = 0;
    logic [7:0]  m_ctrl = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout, expected handshake at %0t", name, $time);
    endtask

    // Reference model: word map straight from the register table
    task automatic m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [29:0] u, output logic [1:0] r);
        r = (a < 12'h01C) ? 2'b00 : 2'b11;
`ifdef PF_CSR_USER_CHECK_EN
        if (u != PFID) r = 2'b10;
`endif
        if (r == 2'b00) begin
            m_wr++;
            for (int b = 0; b < 4; b++)
                if (a / 4 == 1 && s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            if (a / 4 == 2 && s[0]) m_ctrl = d[7:0];
        end else m_err++;
    endtask

    task automatic m_read(input logic [11:0] a, input logic [29:0] u, output logic [33:0] e);
        logic [31:0] v;
        logic [1:0]  r;
        r = (a < 12'h01C) ? 2'b00 : 2'b11;
`ifdef PF_CSR_USER_CHECK_EN
        if (u != PFID) r = 2'b10;
`endif
        case (a / 4)
            0: v = IDV;
            1: v = m_scratch;
            2: v = {24'd0, m_ctrl};
            3: v = status_i;
            4: v = m_wr;
            5: v = m_rd;
            default: v = m_err;
        endcase
        if (r == 2'b00) m_rd++;
        else begin
            v = 0;
            m_err++;
        end
        e = {r, v};
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic hs_write();
        bit a, w;
        for (int t = 0; t < 40 && (s_axil_awvalid || s_axil_wvalid); t++) begin
            @(negedge aclk);
            a = s_axil_awvalid && s_axil_awready;
            w = s_axil_wvalid && s_axil_wready;
            @(posedge aclk);
            #1;
            if (a) s_axil_awvalid = 1'b0;
            if (w) s_axil_wvalid = 1'b0;
        end
        if (s_axil_awvalid || s_axil_wvalid) begin
            fail("write_hs");
            s_axil_awvalid = 1'b0;
            s_axil_wvalid = 1'b0;
        end
    endtask

    // mode 0: AW+W together, 1: W two cycles before AW, 2: AW one cycle before W
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [29:0] u, input int mode, input int bdly, input logic [1:0] e);
        bit got;
        wq.push_back(e);
        s_axil_awaddr = a;
        s_axil_wdata  = d;
        s_axil_wstrb  = s;
        s_axil_awuser = u;
        if (mode == 0) begin
            s_axil_awvalid = 1'b1;
            s_axil_wvalid  = 1'b1;
            hs_write();
        end else if (mode == 1) begin
            s_axil_wvalid = 1'b1;
            hs_write();
            idle(2);
            s_axil_awvalid = 1'b1;
            hs_write();
        end else begin
            s_axil_awvalid = 1'b1;
            hs_write();
            idle(1);
            s_axil_wvalid = 1'b1;
            hs_write();
        end
        @(negedge aclk);
        chk("bvalid_rise", 32'(s_axil_bvalid), 32'd1);
        @(posedge aclk);
        #1;
        for (int i = 0; i < bdly; i++) begin
            s_axil_awvalid = 1'b1;
            @(negedge aclk);
            chk("aw_blocked", 32'(s_axil_awready), 32'd0);
            @(posedge aclk);
            #1;
        end
        s_axil_awvalid = 1'b0;
        s_axil_bready  = 1'b1;
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge aclk);
            got = s_axil_bvalid;
            @(posedge aclk);
            #1;
        end
        s_axil_bready = 1'b0;
        if (!got) fail("bvalid_wait");
        chk("ctrl_o", 32'(ctrl_o), 32'(m_ctrl));
    endtask

    task automatic do_read(input logic [11:0] a, input logic [29:0] u, input int rdly, input logic [33:0] e);
        bit got;
        rq.push_back(e);
        s_axil_araddr  = a;
        s_axil_aruser  = u;
        s_axil_arvalid = 1'b1;
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge aclk);
            got = s_axil_arready;
            @(posedge aclk);
            #1;
        end
        s_axil_arvalid = 1'b0;
        if (!got) fail("ar_hs");
        @(negedge aclk);
        chk("rvalid_rise", 32'(s_axil_rvalid), 32'd1);
        @(posedge aclk);
        #1;
        for (int i = 0; i < rdly; i++) begin
            s_axil_arvalid = 1'b1;
            @(negedge aclk);
            chk("ar_blocked", 32'(s_axil_arready), 32'd0);
            @(posedge aclk);
            #1;
        end
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b1;
        got = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge aclk);
            got = s_axil_rvalid;
            @(posedge aclk);
            #1;
        end
        s_axil_rready = 1'b0;
        if (!got) fail("rvalid_wait");
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [29:0] u, input int mode, input int bdly);
        logic [1:0] e;
        m_write(a, d, s, u, e);
        do_write(a, d, s, u, mode, bdly, e);
    endtask

    task automatic rd(input logic [11:0] a, input logic [29:0] u, input int rdly);
        logic [33:0] e;
        m_read(a, u, e);
        do_read(a, u, rdly, e);
    endtask

    // Read and write issued the same cycle; the read sees pre-write state
    task automatic both(input logic [11:0] ra, input logic [11:0] wa, input logic [31:0] d,
                        input logic [3:0] s, input logic [29:0] u);
        logic [33:0] er;
        logic [1:0]  ew;
        m_read(ra, u, er);
        m_write(wa, d, s, u, ew);
        fork
            do_read(ra, u, 0, er);
            do_write(wa, d, s, u, 0, 0, ew);
        join
    endtask

    // Monitor: pops expectations on each response handshake, checks hold stability
    logic        pb_v = 0, pb_r = 0, pr_v = 0, pr_r = 0;
    logic [1:0]  pb_resp = 0, pr_resp = 0, mon_we;
    logic [31:0] pr_data = 0;
    logic [33:0] mon_re;
    always @(negedge aclk) begin
        if (areset) begin
            pb_v <= 1'b0;
            pr_v <= 1'b0;
        end else begin
            if (pb_v && !pb_r) begin
                chk("bvalid_hold", 32'(s_axil_bvalid), 32'd1);
                chk("bresp_stable", 32'(s_axil_bresp), 32'(pb_resp));
            end
            if (pr_v && !pr_r) begin
                chk("rvalid_hold", 32'(s_axil_rvalid), 32'd1);
                chk("rdata_stable", s_axil_rdata, pr_data);
            end
            if (s_axil_bvalid && s_axil_bready) begin
                if (wq.size() == 0) fail("bresp_unexpected");
                else begin
                    mon_we = wq.pop_front();
                    chk("bresp", 32'(s_axil_bresp), 32'(mon_we));
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (rq.size() == 0) fail("rresp_unexpected");
                else begin
                    mon_re = rq.pop_front();
                    chk("rresp", 32'(s_axil_rresp), 32'(mon_re[33:32]));
                    chk("rdata", s_axil_rdata, mon_re[31:0]);
                end
            end
            pb_v    <= s_axil_bvalid;
            pb_r    <= s_axil_bready;
            pb_resp <= s_axil_bresp;
            pr_v    <= s_axil_rvalid;
            pr_r    <= s_axil_rready;
            pr_data <= s_axil_rdata;
            pr_resp <= s_axil_rresp;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        logic [29:0] u;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", 32'(s_axil_awready), 0);
        chk("rst_wready", 32'(s_axil_wready), 0);
        chk("rst_arready", 32'(s_axil_arready), 0);
        chk("rst_bvalid", 32'(s_axil_bvalid), 0);
        chk("rst_rvalid", 32'(s_axil_rvalid), 0);
        chk("rst_ctrl_o", 32'(ctrl_o), 0);
        chk("rst_rdata", s_axil_rdata, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_awready", 32'(s_axil_awready), 1);
        chk("post_rst_arready", 32'(s_axil_arready), 1);
        @(posedge aclk);
        #1;

        wr(12'h004, 32'h5A5A5A5A, 4'hF, PFID, 0, 0);
        rd(12'h004, PFID, 0);
        rd(12'h010, PFID, 0);
        rd(12'h014, PFID, 0);
        wr(12'h008, 32'hA5A5A5A5, 4'h1, PFID, 1, 0);
        chk("ctrl_o_a5", 32'(ctrl_o), 32'h000000A5);
        rd(12'h008, PFID, 0);
        wr(12'h004, 32'h12345678, 4'h6, PFID, 2, 5);
        rd(12'h004, PFID, 5);
        rd(12'h100, PFID, 0);
        wr(12'h040, 32'hDEADBEEF, 4'hF, PFID, 0, 0);
        rd(12'h018, PFID, 0);
        rd(12'h004, PFID, 0);
        wr(12'h000, 32'hFFFFFFFF, 4'hF, PFID, 0, 0);
        rd(12'h000, PFID, 0);
`ifdef PF_CSR_USER_CHECK_EN
        wr(12'h004, 32'h0BADF00D, 4'hF, 30'd2, 0, 0);
        rd(12'h004, PFID, 0);
        wr(12'h004, 32'h600DF00D, 4'hF, 30'd1, 0, 0);
        rd(12'h000, 30'd1, 0);
        rd(12'h004, 30'd3, 0);
`endif
        both(12'h004, 12'h004, 32'hCAFEF00D, 4'hF, PFID);
        both(12'h010, 12'h008, 32'h0000003C, 4'h1, PFID);
        both(12'h018, 12'h100, 32'h1, 4'hF, PFID);
        rd(12'h004, PFID, 0);

        for (int it = 0; it < 200; it++) begin
            a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
            u = ($urandom_range(0, 4) == 0) ? PFID + 30'd1 : PFID;
            status_i = $urandom;
            case ($urandom_range(0, 2))
                0: wr(a, $urandom, 4'($urandom), u, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
                1: rd(a, u, int'($urandom_range(0, 3)));
                default: both(12'($urandom_range(0, 31)), a, $urandom, 4'($urandom), u);
            endcase
        end

        s_axil_awaddr  = 12'h004;
        s_axil_awuser  = PFID;
        s_axil_awvalid = 1'b1;
        hs_write();
        areset = 1'b1;
        @(negedge aclk);
        chk("mid_rst_awready", 32'(s_axil_awready), 0);
        chk("mid_rst_wready", 32'(s_axil_wready), 0);
        chk("mid_rst_bvalid", 32'(s_axil_bvalid), 0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("mid_rst_ctrl_o", 32'(ctrl_o), 0);
        chk("mid_rst_bresp", 32'(s_axil_bresp), 0);
        chk("mid_rst_rresp", 32'(s_axil_rresp), 0);
        chk("mid_rst_rdata", s_axil_rdata, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        m_scratch = 0;
        m_ctrl = 0;
        m_wr = 0;
        m_rd = 0;
        m_err = 0;
        rd(12'h004, PFID, 0);
        rd(12'h010, PFID, 0);
        rd(12'h018, PFID, 0);
        wr(12'h004, 32'h0F0F1234, 4'hF, PFID, 2, 1);
        rd(12'h004, PFID, 0);
        rd(12'h010, PFID, 0);

        for (int t = 0; t < 20 && (wq.size() != 0 || rq.size() != 0); t++) @(posedge aclk);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pf_csr_regfile.md
PF_CSR_REGFILE -- requirements
Module: pf_csr_regfile

Interface
REQ-001 Parameter: PF_ID, default 0, 30-bit physical-function number this bank answers to.
REQ-002 Parameter: ID_VALUE, default 32'h0CF5_0001, constant returned by the ID register.
REQ-003 aclk  in  1  sole clock; all logic rising-edge.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 s_axil_awaddr  in  12  write byte address.
REQ-006 s_axil_awuser  in  30  write PF tag from upstream PF demux.
REQ-007 s_axil_awvalid / s_axil_awready  in / out  1 / 1  AW handshake.
REQ-008 s_axil_wdata / s_axil_wstrb  in  32 / 4  write data and byte enables.
REQ-009 s_axil_wvalid / s_axil_wready  in / out  1 / 1  W handshake.
REQ-010 s_axil_bresp / s_axil_bvalid / s_axil_bready  out / out / in  2 / 1 / 1  write response.
REQ-011 s_axil_araddr / s_axil_aruser  in  12 / 30  read address and PF tag.
REQ-012 s_axil_arvalid / s_axil_arready  in / out  1 / 1  AR handshake.
REQ-013 s_axil_rdata / s_axil_rresp / s_axil_rvalid / s_axil_rready  out / out / out / in  32 / 2 / 1 / 1  read response.
REQ-014 status_i  in  32  live status, sampled at read capture.
REQ-015 ctrl_o  out  8  CTRL[7:0] register contents.

Function
REQ-016 Register map (word index = addr[5:2], addr[11:6] must be 0, addr[1:0] ignored): 0x00 ID RO; 0x04 SCRATCH RW; 0x08 CTRL RW bits [7:0], upper bits read 0; 0x0C STATUS RO = status_i; 0x10 WR_CNT RO; 0x14 RD_CNT RO; 0x18 ERR_CNT RO; all other addresses unmapped.
REQ-017 Write FSM states: W_IDLE (awready=1, wready=1), W_HAVE_A (awready=0, wready=1), W_HAVE_D (awready=1, wready=0), W_RESP (both ready=0, bvalid=1).
REQ-018 AW and W accepted in either order or the same cycle; the cycle both are held, FSM moves to W_RESP and commits the write on that same edge; bvalid rises the cycle after the final handshake.
REQ-019 Write commit honours wstrb per byte; writes to RO registers are accepted with OKAY and change nothing; unmapped writes return DECERR (2'b11) and change nothing.
REQ-020 bvalid and bresp held stable until bready=1; W_RESP -> W_IDLE on that edge; no new AW/W accepted while in W_RESP.
REQ-021 Read FSM: R_IDLE (arready=1, rvalid=0) -> R_RESP on AR handshake; rdata/rresp registered on that edge from current register values; rvalid=1 the next cycle, held with stable data until rready=1, then R_IDLE.
REQ-022 Unmapped read: rdata=0, rresp=DECERR.
REQ-023 WR_CNT increments by 1 per OKAY write commit (including RO targets); RD_CNT increments by 1 per OKAY read capture; ERR_CNT increments by 1 per non-OKAY response; all 32-bit, wrap 0xFFFF_FFFF -> 0.
REQ-024 Read capture and write commit in the same cycle to the same register: read returns the pre-write value.
REQ-025 Read and write paths are independent; one outstanding transaction per path.
REQ-026 Read of WR_CNT/RD_CNT/ERR_CNT returns the value before any increment caused by the same-cycle event.

Reset
REQ-027 While areset=1: both FSMs to idle; awready=wready=arready=0 during reset; bvalid=rvalid=0; bresp=rresp=0; rdata=0; SCRATCH, CTRL, WR_CNT, RD_CNT, ERR_CNT = 0; ctrl_o=0.
REQ-028 Reset mid-transaction discards any pending address/data/response; no register update and no counter increment occur for it.
REQ-029 Ready outputs reassert the first cycle after areset falls.

Configuration
REQ-030 Macro PF_CSR_USER_CHECK_EN defined: awuser/aruser captured with the address; tag != PF_ID yields SLVERR (2'b10), no write, rdata=0, ERR_CNT increments; tag checked before address decode.
REQ-031 Macro undefined: awuser/aruser ignored; behaviour per REQ-016..REQ-026 only.

Verification
REQ-032 AW and W same cycle, addr 0x04, data 0x5A5A5A5A, wstrb 0xF -> bvalid next cycle, OKAY; read 0x04 -> 0x5A5A5A5A OKAY; WR_CNT=1, RD_CNT=1.
REQ-033 W two cycles before AW, addr 0x08, data 0xA5A5A5A5, wstrb 0x1 -> ctrl_o=0xA5, read 0x08 -> 0x000000A5.
REQ-034 bready held low 5 cycles -> bvalid and bresp stable throughout, no second AW accepted; same for rvalid/rdata with rready low.
REQ-035 Read 0x100 and write 0x40 -> DECERR both, rdata=0, ERR_CNT=2, SCRATCH unchanged.
REQ-036 With PF_CSR_USER_CHECK_EN, PF_ID=1: write 0x04 with awuser=2 -> SLVERR, SCRATCH unchanged; awuser=1 -> OKAY; read ID with aruser=1 -> 0x0CF50001.
REQ-037 areset pulsed while in W_HAVE_A -> all outputs at reset values, SCRATCH and counters 0, subsequent write completes normally.
